led_frame_buffer: RTL and testbench
===================================

# led_frame_buffer

Parametrised, double-buffered frame store between game logic and `matrix_ctrl`. Game logic edits a back buffer row by row, then requests a commit. The front buffer is updated only at a scan-frame boundary, so the display never tears. The block serves the column-transposed `disp_data` for the `disp_addr` driven by `matrix_ctrl`, adds selectable mirroring, and can blink the display. It replaces the fixed-pattern register/mux logic in the system top level.

## Interface
Parameters:
- `DATAWIDTH_BUS`, 8: columns per row; row word width.
- `ROWS`, 8: number of rows; also the `disp_data` width.
- `ADDR_W`, 3: width of the row-write and scan addresses.
- `BLINK_DIV`, 12500000: clock cycles per blink half-period; must be ≥2.
- `BLINK_W`, 24: blink counter width; must satisfy BLINK_DIV-1 < 2^BLINK_W.

Ports:
- `LED_FRAME_BUFFER_CLOCK_50`, in, 1: the single clock.
- `LED_FRAME_BUFFER_RESET_InHigh`, in, 1: synchronous, active-high reset.
- `LED_FRAME_BUFFER_wrEn_In`, in, 1: writes `wrData` to back-buffer row `wrRow`.
- `LED_FRAME_BUFFER_wrRow_In`, in, ADDR_W: back-buffer row index.
- `LED_FRAME_BUFFER_wrData_In`, in, DATAWIDTH_BUS: row data; bit DATAWIDTH_BUS-1 is the leftmost column.
- `LED_FRAME_BUFFER_commit_In`, in, 1: single-cycle commit request.
- `LED_FRAME_BUFFER_mode_In`, in, 2: orientation. bit0 mirrors horizontally; bit1 flips vertically.
- `LED_FRAME_BUFFER_blink_In`, in, 1: blink enable.
- `LED_FRAME_BUFFER_dispAddr_In`, in, ADDR_W: scan column from `matrix_ctrl`.
- `LED_FRAME_BUFFER_dispData_Out`, out, ROWS: column data to `matrix_ctrl`.
- `LED_FRAME_BUFFER_busy_Out`, out, 1: a commit is pending.
- `LED_FRAME_BUFFER_done_Out`, out, 1: one-cycle pulse after a swap.

## Operation
- State: back[ROWS], front[ROWS], mode_q[1:0], pending, addr_q, blink counter, blink phase.
- Write: when wrEn=1 and wrRow<ROWS, back[wrRow] is updated at the next clock edge. A write with wrRow≥ROWS is ignored.
- Frame boundary (fb): addr_q≠dispAddr_In and dispAddr_In=0. addr_q registers dispAddr_In every cycle.
- Commit FSM, IDLE→PEND→IDLE:
  - IDLE: commit_In=1 sets pending. If the same cycle is also an fb, the swap happens at that fb.
  - PEND: the swap happens at the next fb. Further commits are coalesced into the same swap.
- Swap, at the fb edge:
  - front ← back (copy); back is unchanged.
  - mode_q ← mode_In.
  - pending ← 0; done=1 for the next cycle.
  - If a write occurs in the swap cycle, front receives the pre-write back contents and the write lands in back only.
- Readout (combinational from front, mode_q and dispAddr), with c = dispAddr:
  - Horizontal: mode_q[0]=0 uses bit DATAWIDTH_BUS-1-c; mode_q[0]=1 uses bit c.
  - Vertical: mode_q[1]=0 places row r at dispData[ROWS-1-r]; mode_q[1]=1 places row r at dispData[r].
  - c≥DATAWIDTH_BUS outputs all zeros.
- Blink: see Configuration. When blanked, dispData=0. front is never modified by blinking.
- busy = pending.

## Timing
- Reset (synchronous) clears: back, front, mode_q, pending, done, addr_q, blink counter and phase.
- After reset, dispData=0, busy=0 and done=0.
- Reset asserted while a commit is pending cancels the commit; no done pulse follows.
- Reset has priority over writes, commits and swaps in the same cycle.
- Latencies:
  - Write to back: 1 cycle.
  - Commit to busy high: 1 cycle.
  - Swap to visible data: 0 cycles after the swap edge.
  - Swap edge to done: done is high for exactly the 1 cycle after the swap edge.
- dispAddr to dispData: combinational, 0 cycles.
- A commit is never lost. Maximum wait is one full scan frame.

## Configuration
- `LED_FRAME_BUFFER_BLINK_EN` defined:
  - The counter counts 0..BLINK_DIV-1 and wraps; phase toggles on each wrap.
  - The counter runs only while blink_In=1. When blink_In=0, the counter and phase are held at 0.
  - Output is blanked while blink_In=1 and phase=1.
- Not defined: no counter or phase logic is built; blink_In is ignored and the output is never blanked.

## Test plan
- Reset, then scan dispAddr 0..7 -> dispData=8'h00 at every address; busy=0, done=0.
- Write row0=8'h80 with no commit, then scan -> all zeros. Commit with dispAddr held at 3 -> busy=1. Step dispAddr 4..7 then 0 -> swap at the 7→0 edge, done pulse of 1 cycle, busy=0. At addr 0, dispData=8'h80.
- Same frame with mode=01 committed -> dispData=8'h80 at addr 7 and 0 elsewhere. With mode=11 -> dispData=8'h01 at addr 7.
- Three commits in one frame, plus a row write in the swap cycle -> exactly one done pulse. front lacks the late write; back holds it, and it appears after the next commit.
- Commit, then reset before the fb -> busy=0, no done, front=0. A write to wrRow=8 (ROWS=8) is ignored; out-of-range dispAddr (ADDR_W>3 build) returns 0.
- With BLINK_EN, BLINK_DIV=4, blink=1 and front nonzero -> dispData alternates between frame data and 0 every 4 cycles. Without BLINK_EN -> always frame data.

Source files
------------

// File: rtl/led_frame_buffer.sv
// led_frame_buffer: double-buffered LED frame store between game logic and matrix_ctrl.
// Game logic fills the back buffer row by row and requests a commit; the front buffer
// is refreshed from the back buffer only when the scan wraps to column 0, so the
// display never tears. The scan side reads one column per address, with optional
// horizontal/vertical mirroring selected at commit time.
// Optional feature: define LED_FRAME_BUFFER_BLINK_EN to build the blink timebase.
module led_frame_buffer #(
    parameter int DATAWIDTH_BUS = 8,
    parameter int ROWS          = 8,
    parameter int ADDR_W        = 3,
    parameter int BLINK_DIV     = 12500000,
    parameter int BLINK_W       = 24
) (
    input  logic                     LED_FRAME_BUFFER_CLOCK_50,
    input  logic                     LED_FRAME_BUFFER_RESET_InHigh,
    input  logic                     LED_FRAME_BUFFER_wrEn_In,
    input  logic [ADDR_W-1:0]        LED_FRAME_BUFFER_wrRow_In,
    input  logic [DATAWIDTH_BUS-1:0] LED_FRAME_BUFFER_wrData_In,
    input  logic                     LED_FRAME_BUFFER_commit_In,
    input  logic [1:0]               LED_FRAME_BUFFER_mode_In,
    input  logic                     LED_FRAME_BUFFER_blink_In,
    input  logic [ADDR_W-1:0]        LED_FRAME_BUFFER_dispAddr_In,
    output logic [ROWS-1:0]          LED_FRAME_BUFFER_dispData_Out,
    output logic                     LED_FRAME_BUFFER_busy_Out,
    output logic                     LED_FRAME_BUFFER_done_Out
);

    typedef enum logic {
        IDLE,
        PEND
    } commitState_t;

    commitState_t      commitState;
    commitState_t      commitStateNext;
    logic              swap;
    logic              frameBoundary;
    logic [ADDR_W-1:0] addrQ;
    logic [1:0]        modeQ;
    logic              doneQ;
    logic [31:0]       colIdx;
    logic              colValid;
    logic [ROWS-1:0]   rowBit;
    logic [ROWS-1:0]   rowBitRev;
    logic [ROWS-1:0]   colBits;
    logic              blanked;

    // A frame starts when the scan address moves onto column 0.
    assign frameBoundary = (addrQ != LED_FRAME_BUFFER_dispAddr_In) &&
                           (LED_FRAME_BUFFER_dispAddr_In == '0);

    // Commit FSM state register; reset drops any pending commit.
    always_ff @(posedge LED_FRAME_BUFFER_CLOCK_50) begin
        if (LED_FRAME_BUFFER_RESET_InHigh) begin
            commitState <= IDLE;
        end else begin
            commitState <= commitStateNext;
        end
    end

    // Commit FSM next state and swap strobe; extra commits while pending coalesce.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        commitStateNext = commitState;
        swap            = 1'b0;
        case (commitState)
            IDLE: begin
                if (LED_FRAME_BUFFER_commit_In) begin
                    if (frameBoundary) begin
                        swap = 1'b1;
                    end else begin
                        commitStateNext = PEND;
                    end
                end
            end
            PEND: begin
                if (frameBoundary) begin
                    swap            = 1'b1;
                    commitStateNext = IDLE;
                end
            end
            default: commitStateNext = IDLE;
        endcase
    end

    // Scan address history, latched orientation and the post-swap done pulse.
    always_ff @(posedge LED_FRAME_BUFFER_CLOCK_50) begin
        if (LED_FRAME_BUFFER_RESET_InHigh) begin
            addrQ <= '0;
            modeQ <= '0;
            doneQ <= 1'b0;
        end else begin
            addrQ <= LED_FRAME_BUFFER_dispAddr_In;
            doneQ <= swap;
            if (swap) begin
                modeQ <= LED_FRAME_BUFFER_mode_In;
            end
        end
    end

    // Column bit selected from each row: left-to-right normally, right-to-left when mirrored.
    assign colIdx = modeQ[0] ? 32'(LED_FRAME_BUFFER_dispAddr_In)
                             : 32'(DATAWIDTH_BUS - 1) - 32'(LED_FRAME_BUFFER_dispAddr_In);
    assign colValid = 32'(LED_FRAME_BUFFER_dispAddr_In) < DATAWIDTH_BUS;

    for (genvar r = 0; r < ROWS; r++) begin : gRow
        logic [DATAWIDTH_BUS-1:0] backRow;
        logic [DATAWIDTH_BUS-1:0] frontRow;
        logic [DATAWIDTH_BUS-1:0] shifted;

        // Row storage: back takes writes, front copies back on a swap.
        always_ff @(posedge LED_FRAME_BUFFER_CLOCK_50) begin
            // NOTE: the frame is held in flops, not RAM, so reset can and does clear every row.
            if (LED_FRAME_BUFFER_RESET_InHigh) begin
                backRow  <= '0;
                frontRow <= '0;
            end else begin
                // NOTE: non-blocking assignment makes front take the pre-write back row
                // when a write and a swap share the same edge.
                if (swap) begin
                    frontRow <= backRow;
                end
                if (LED_FRAME_BUFFER_wrEn_In && (32'(LED_FRAME_BUFFER_wrRow_In) == r)) begin
                    backRow <= LED_FRAME_BUFFER_wrData_In;
                end
            end
        end

        assign shifted              = frontRow >> colIdx;
        assign rowBit[r]            = shifted[0];
        assign rowBitRev[ROWS-1-r]  = shifted[0];
    end

    // Row 0 sits at the top output bit unless the vertical flip is latched.
    assign colBits = modeQ[1] ? rowBit : rowBitRev;

`ifdef LED_FRAME_BUFFER_BLINK_EN
    logic [BLINK_W-1:0] blinkCnt;
    logic               blinkPhase;

    // Blink timebase: runs only while blink is enabled, phase toggles on each wrap.
    always_ff @(posedge LED_FRAME_BUFFER_CLOCK_50) begin
        if (LED_FRAME_BUFFER_RESET_InHigh || !LED_FRAME_BUFFER_blink_In) begin
            blinkCnt   <= '0;
            blinkPhase <= 1'b0;
        end else if (blinkCnt == BLINK_W'(BLINK_DIV - 1)) begin
            blinkCnt   <= '0;
            blinkPhase <= ~blinkPhase;
        end else begin
            blinkCnt <= blinkCnt + BLINK_W'(1);
        end
    end

    assign blanked = LED_FRAME_BUFFER_blink_In && blinkPhase;
`else
    logic unusedBlink;

    // Without the blink timebase the enable and its sizing parameters have no effect.
    assign unusedBlink = LED_FRAME_BUFFER_blink_In | (BLINK_DIV < 2) | (BLINK_W < 1);
    assign blanked     = 1'b0;
`endif

    assign LED_FRAME_BUFFER_dispData_Out = (blanked || !colValid) ? '0 : colBits;
    assign LED_FRAME_BUFFER_busy_Out     = (commitState == PEND);
    assign LED_FRAME_BUFFER_done_Out     = doneQ;

endmodule

// File: tb/tb_led_frame_buffer.sv
// Self-checking bench for led_frame_buffer: scan readout, commit/swap timing,
// orientation modes, commit coalescing, reset cancel, range limits and blinking.
module tb_led_frame_buffer;

    localparam int COLS = 8;
    localparam int ROWS = 8;
    localparam int AW   = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            wrEn = 1'b0;
    logic [AW-1:0]   wrRow = '0;
    logic [COLS-1:0] wrData = '0;
    logic            commit = 1'b0;
    logic [1:0]      mode = 2'b00;
    logic            blink = 1'b0;
    logic [AW-1:0]   dispAddr = '0;
    logic [ROWS-1:0] dispData;
    logic            busy;
    logic            done;

    int total = 0;
    int bad   = 0;

    logic [COLS-1:0] modelBack [ROWS];
    logic [COLS-1:0] modelFront[ROWS];
    logic [1:0]      modelMode;

    typedef struct {
        string           tag;
        logic [ROWS-1:0] val;
    } exp_t;

    exp_t            expQ[$];
    logic [ROWS-1:0] obsQ[$];

    led_frame_buffer #(
        .DATAWIDTH_BUS(COLS),
        .ROWS(ROWS),
        .ADDR_W(AW),
        .BLINK_DIV(4),
        .BLINK_W(3)
    ) dut (
        .LED_FRAME_BUFFER_CLOCK_50(clk),
        .LED_FRAME_BUFFER_RESET_InHigh(rst),
        .LED_FRAME_BUFFER_wrEn_In(wrEn),
        .LED_FRAME_BUFFER_wrRow_In(wrRow),
        .LED_FRAME_BUFFER_wrData_In(wrData),
        .LED_FRAME_BUFFER_commit_In(commit),
        .LED_FRAME_BUFFER_mode_In(mode),
        .LED_FRAME_BUFFER_blink_In(blink),
        .LED_FRAME_BUFFER_dispAddr_In(dispAddr),
        .LED_FRAME_BUFFER_dispData_Out(dispData),
        .LED_FRAME_BUFFER_busy_Out(busy),
        .LED_FRAME_BUFFER_done_Out(done)
    );

    always #5 clk = ~clk;

    // Expected column word from the bench model of the front buffer.
    function automatic logic [ROWS-1:0] expCol(input int c);
        logic [ROWS-1:0] res;
        int hb;
        int vb;
        res = '0;
        if (c >= COLS) return '0;
        for (int r = 0; r < ROWS; r++) begin
            hb = modelMode[0] ? c : COLS - 1 - c;
            vb = modelMode[1] ? r : ROWS - 1 - r;
            res[vb] = modelFront[r][hb];
        end
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        for (int r = 0; r < ROWS; r++) begin
            modelBack[r]  = '0;
            modelFront[r] = '0;
        end
        modelMode = 2'b00;
    endtask

    task automatic writeRow(input int row, input logic [COLS-1:0] data);
        wrEn   = 1'b1;
        wrRow  = AW'(row);
        wrData = data;
        tick();
        wrEn = 1'b0;
        if (row < ROWS) modelBack[row] = data;
    endtask

    // Drive scan addresses lo..hi, pushing model expectations and recording DUT output.
    task automatic scanRange(input int lo, input int hi, input string tag);
        for (int a = lo; a <= hi; a++) begin
            dispAddr = AW'(a);
            expQ.push_back('{tag: $sformatf("%s a=%0d", tag, a), val: expCol(a)});
            @(negedge clk);
            obsQ.push_back(dispData);
            tick();
        end
    endtask

    // Commit(s) mid-frame, then walk to the 7->0 boundary; optional write in the swap cycle.
    task automatic commitFrame(input logic [1:0] m, input int n, input bit late,
                               input int lateRow, input logic [COLS-1:0] lateData,
                               output int doneCount, output logic busyAfterCommit,
                               output logic busyBeforeSwap, output logic doneAfterSwap,
                               output logic busyAfterSwap, output logic [ROWS-1:0] dataAtZero);
        doneCount       = 0;
        busyAfterCommit = 1'b0;
        mode            = m;
        for (int k = 0; k < n; k++) begin
            dispAddr = AW'(3 + k);
            commit   = 1'b1;
            tick();
            commit = 1'b0;
            doneCount += int'(done);
            if (k == 0) busyAfterCommit = busy;
        end
        for (int a = 3 + n; a <= 7; a++) begin
            dispAddr = AW'(a);
            tick();
            doneCount += int'(done);
        end
        busyBeforeSwap = busy;
        dispAddr = '0;
        if (late) begin
            wrEn   = 1'b1;
            wrRow  = AW'(lateRow);
            wrData = lateData;
        end
        tick();
        wrEn = 1'b0;
        doneAfterSwap = done;
        busyAfterSwap = busy;
        dataAtZero    = dispData;
        doneCount += int'(done);
        for (int k = 0; k < 3; k++) begin
            tick();
            doneCount += int'(done);
        end
        for (int r = 0; r < ROWS; r++) modelFront[r] = modelBack[r];
        modelMode = m;
        if (late && lateRow < ROWS) modelBack[lateRow] = lateData;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [ROWS-1:0] o;
        rst = 1'b1;
        modelReset();
        tick();
        tick();
        rst = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL reset_done got=%b exp=0", done);
        end
        scanRange(0, 7, "reset_scan");
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            total++;
            if (o !== e.val) begin
                bad++;
                $display("FAIL %s got=%h exp=%h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic test_commit();
        exp_t e;
        logic [ROWS-1:0] o;
        int dc;
        logic bc, bb, da, ba;
        logic [ROWS-1:0] d0;
        writeRow(0, 8'h80);
        scanRange(0, 7, "precommit_scan");
        commitFrame(2'b00, 1, 1'b0, 0, '0, dc, bc, bb, da, ba, d0);
        total++;
        if (bc !== 1'b1) begin bad++; $display("FAIL commit_busy_rise got=%b exp=1", bc); end
        total++;
        if (bb !== 1'b1) begin bad++; $display("FAIL commit_busy_hold got=%b exp=1", bb); end
        total++;
        if (da !== 1'b1) begin bad++; $display("FAIL commit_done_pulse got=%b exp=1", da); end
        total++;
        if (ba !== 1'b0) begin bad++; $display("FAIL commit_busy_clear got=%b exp=0", ba); end
        total++;
        if (dc !== 1) begin bad++; $display("FAIL commit_done_count got=%0d exp=1", dc); end
        total++;
        if (d0 !== 8'h80) begin bad++; $display("FAIL commit_addr0 got=%h exp=80", d0); end
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            total++;
            if (o !== e.val) begin
                bad++;
                $display("FAIL %s got=%h exp=%h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic test_mode();
        exp_t e;
        logic [ROWS-1:0] o;
        int dc;
        logic bc, bb, da, ba;
        logic [ROWS-1:0] d0;
        commitFrame(2'b01, 1, 1'b0, 0, '0, dc, bc, bb, da, ba, d0);
        scanRange(0, 7, "mode01_scan");
        dispAddr = 3'd7;
        #1;
        total++;
        if (dispData !== 8'h80) begin bad++; $display("FAIL mode01_addr7 got=%h exp=80", dispData); end
        commitFrame(2'b11, 1, 1'b0, 0, '0, dc, bc, bb, da, ba, d0);
        scanRange(0, 7, "mode11_scan");
        dispAddr = 3'd7;
        #1;
        total++;
        if (dispData !== 8'h01) begin bad++; $display("FAIL mode11_addr7 got=%h exp=01", dispData); end
        commitFrame(2'b00, 1, 1'b0, 0, '0, dc, bc, bb, da, ba, d0);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            total++;
            if (o !== e.val) begin
                bad++;
                $display("FAIL %s got=%h exp=%h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [ROWS-1:0] o;
        int dc;
        logic bc, bb, da, ba;
        logic [ROWS-1:0] d0;
        writeRow(2, 8'h3C);
        commitFrame(2'b00, 3, 1'b1, 5, 8'hFF, dc, bc, bb, da, ba, d0);
        total++;
        if (dc !== 1) begin bad++; $display("FAIL coalesce_done_count got=%0d exp=1", dc); end
        total++;
        if (d0 !== 8'h80) begin bad++; $display("FAIL coalesce_addr0 got=%h exp=80", d0); end
        scanRange(0, 7, "coalesce_scan");
        commitFrame(2'b00, 1, 1'b0, 0, '0, dc, bc, bb, da, ba, d0);
        total++;
        if (dc !== 1) begin bad++; $display("FAIL late_write_done_count got=%0d exp=1", dc); end
        total++;
        if (d0 !== 8'h84) begin bad++; $display("FAIL late_write_addr0 got=%h exp=84", d0); end
        scanRange(0, 7, "late_write_scan");
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            total++;
            if (o !== e.val) begin
                bad++;
                $display("FAIL %s got=%h exp=%h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic test_reset_cancel();
        exp_t e;
        logic [ROWS-1:0] o;
        int dc;
        writeRow(1, 8'hFF);
        dispAddr = 3'd3;
        commit   = 1'b1;
        tick();
        commit = 1'b0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL cancel_busy_set got=%b exp=1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        modelReset();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL cancel_busy_clear got=%b exp=0", busy); end
        dc = int'(done);
        for (int a = 4; a <= 8; a++) begin
            dispAddr = (a == 8) ? '0 : AW'(a);
            tick();
            dc += int'(done);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            dc += int'(done);
        end
        total++;
        if (dc !== 0) begin bad++; $display("FAIL cancel_no_done got=%0d exp=0", dc); end
        scanRange(0, 7, "cancel_scan");
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            total++;
            if (o !== e.val) begin
                bad++;
                $display("FAIL %s got=%h exp=%h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic test_out_of_range();
        exp_t e;
        logic [ROWS-1:0] o;
        int dc;
        logic bc, bb, da, ba;
        logic [ROWS-1:0] d0;
        writeRow(0, 8'hA5);
        writeRow(8, 8'hFF);
        commitFrame(2'b00, 1, 1'b0, 0, '0, dc, bc, bb, da, ba, d0);
        total++;
        if (d0 !== 8'h80) begin bad++; $display("FAIL range_addr0 got=%h exp=80", d0); end
        scanRange(0, 7, "range_scan");
        scanRange(8, 15, "range_high_addr");
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            total++;
            if (o !== e.val) begin
                bad++;
                $display("FAIL %s got=%h exp=%h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic test_blink();
        exp_t e;
        logic [ROWS-1:0] o;
        logic [ROWS-1:0] want;
        bit blinkBuilt;
`ifdef LED_FRAME_BUFFER_BLINK_EN
        blinkBuilt = 1'b1;
`else
        blinkBuilt = 1'b0;
`endif
        dispAddr = '0;
        blink    = 1'b1;
        for (int k = 0; k < 16; k++) begin
            want = (blinkBuilt && ((k / 4) % 2 == 1)) ? '0 : expCol(0);
            expQ.push_back('{tag: $sformatf("blink k=%0d", k), val: want});
            @(negedge clk);
            obsQ.push_back(dispData);
            tick();
        end
        blink = 1'b0;
        expQ.push_back('{tag: "blink_off", val: expCol(0)});
        tick();
        @(negedge clk);
        obsQ.push_back(dispData);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            total++;
            if (o !== e.val) begin
                bad++;
                $display("FAIL %s got=%h exp=%h", e.tag, o, e.val);
            end
        end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_mode();
        test_back_to_back();
        test_reset_cancel();
        test_out_of_range();
        test_blink();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
